// File: rtl/quad_bcd_count_ctrl_if.sv
// Encoder, control and display-count signals for the quadrature BCD counter front end.
interface quad_bcd_count_ctrl_if;
    logic       enc_a;
    logic       enc_b;
    logic       clear;
    logic       count_en;
    logic       up;
    logic       down;
    logic       dir;
    logic       err;
    logic [3:0] bcd_lsb;
    logic [3:0] bcd_mid;
    logic [3:0] bcd_msb;

    modport master (
        output enc_a, enc_b, clear, count_en,
        input  up, down, dir, err, bcd_lsb, bcd_mid, bcd_msb
    );

    modport slave (
        input  enc_a, enc_b, clear, count_en,
        output up, down, dir, err, bcd_lsb, bcd_mid, bcd_msb
    );
endinterface

// File: rtl/quad_bcd_count_ctrl.sv
// Quadrature encoder front end: sync, debounce, Gray decode to detent strobes,
// and a 000-999 BCD up/down count with wrap or saturate at the limits.
module quad_bcd_count_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int COUNTS_PER_DETENT = 4,
    parameter bit WRAP              = 1'b1
) (
    input logic                 sample_clk,
    input logic                 reset_n,
    quad_bcd_count_ctrl_if.slave io
);

    localparam logic [3:0]        DB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]        INIT_LAST = 5'(DEBOUNCE_CYCLES + 1);
    localparam logic signed [3:0] ACC_TOP   = 4'(COUNTS_PER_DETENT);
    localparam logic signed [3:0] ACC_BOT   = -ACC_TOP;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [4:0]        init_cnt;
    logic [1:0]        sync_p0;
    logic [1:0]        sync_p1;
    logic [1:0]        filt;
    logic [3:0]        db_cnt [2];
    logic [1:0]        prev;
    logic signed [3:0] acc;
    logic signed [3:0] step;
    logic signed [3:0] acc_next;
    logic              illegal;
    logic [11:0]       count;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == 12'h999) begin
            r = WRAP ? 12'h000 : v;
        end else if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == 12'h000) begin
            r = WRAP ? 12'h999 : v;
        end else if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4]  = 4'd9;
                r[11:8] = v[11:8] - 4'd1;
            end
        end
        return r;
    endfunction

    // Stage p0/p1: two-flop synchroniser for both raw phases
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 2'b00;
            sync_p1 <= 2'b00;
        end else begin
            sync_p0 <= {io.enc_a, io.enc_b};
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: a phase flips only after DEBOUNCE_CYCLES consecutive mismatches
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            filt      <= 2'b00;
            db_cnt[0] <= 4'd0;
            db_cnt[1] <= 4'd0;
        end else if (state == INIT) begin
            filt      <= sync_p1;
            db_cnt[0] <= 4'd0;
            db_cnt[1] <= 4'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] != filt[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        filt[i]   <= sync_p1[i];
                        db_cnt[i] <= 4'd0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 4'd1;
                    end
                end else begin
                    db_cnt[i] <= 4'd0;
                end
            end
        end
    end

    always_comb begin
        step    = 4'sd0;
        illegal = 1'b0;
        case ({prev, filt})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: step = 4'sd1;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: step = -4'sd1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
            default: step = 4'sd0;
        endcase
        acc_next = acc + step;
    end

    // Decode stage: accumulate quarter-steps, emit strobes, update the count
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            init_cnt <= 5'd0;
            prev     <= 2'b00;
            acc      <= 4'sd0;
            io.up    <= 1'b0;
            io.down  <= 1'b0;
            io.dir   <= 1'b0;
            io.err   <= 1'b0;
            count    <= 12'h000;
        end else begin
            io.up   <= 1'b0;
            io.down <= 1'b0;
            if (state == INIT) begin
                if (init_cnt == INIT_LAST) state <= RUN;
                else                       init_cnt <= init_cnt + 5'd1;
            end
            if (io.clear) begin
                count  <= 12'h000;
                acc    <= 4'sd0;
                io.err <= 1'b0;
                prev   <= (state == INIT) ? sync_p1 : filt;
            end else if (state == INIT) begin
                prev <= sync_p1;
            end else begin
                prev <= filt;
                if (illegal) io.err <= 1'b1;
                if (acc_next == ACC_TOP) begin
                    acc    <= 4'sd0;
                    io.up  <= 1'b1;
                    io.dir <= 1'b1;
                    if (io.count_en) count <= bcd_inc(count);
                end else if (acc_next == ACC_BOT) begin
                    acc     <= 4'sd0;
                    io.down <= 1'b1;
                    io.dir  <= 1'b0;
                    if (io.count_en) count <= bcd_dec(count);
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

    assign io.bcd_msb = count[11:8];
    assign io.bcd_mid = count[7:4];
    assign io.bcd_lsb = count[3:0];

endmodule

// File: tb/tb_quad_bcd_count_ctrl.sv
// Bench for quad_bcd_count_ctrl: a wrapping and a saturating instance share one
// encoder stimulus and are compared against a position/count model.
module tb_quad_bcd_count_ctrl;

    localparam int DEB = 4;
    localparam int CPD = 4;
    localparam int LAT = 3 + DEB;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    quad_bcd_count_ctrl_if bw();
    quad_bcd_count_ctrl_if bs();

    assign bs.enc_a    = bw.enc_a;
    assign bs.enc_b    = bw.enc_b;
    assign bs.clear    = bw.clear;
    assign bs.count_en = bw.count_en;

    quad_bcd_count_ctrl #(.DEBOUNCE_CYCLES(DEB), .COUNTS_PER_DETENT(CPD), .WRAP(1'b1)) dut_w (
        .sample_clk(clk), .reset_n(reset_n), .io(bw.slave));
    quad_bcd_count_ctrl #(.DEBOUNCE_CYCLES(DEB), .COUNTS_PER_DETENT(CPD), .WRAP(1'b0)) dut_s (
        .sample_clk(clk), .reset_n(reset_n), .io(bs.slave));

    int total = 0;
    int bad = 0;
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int idx, acc, cnt_w, cnt_s, exp_dir, exp_err;
    int nu_w, nd_w, nu_s, nd_s, pos_u, pos_d, both;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] bcd_of(input int c);
        return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_bcd_w"}, {20'd0, bw.bcd_msb, bw.bcd_mid, bw.bcd_lsb}, {20'd0, bcd_of(cnt_w)});
        check({tag, "_bcd_s"}, {20'd0, bs.bcd_msb, bs.bcd_mid, bs.bcd_lsb}, {20'd0, bcd_of(cnt_s)});
        check({tag, "_dir"}, {30'd0, bw.dir, bs.dir}, {30'd0, exp_dir[0], exp_dir[0]});
        check({tag, "_err"}, {30'd0, bw.err, bs.err}, {30'd0, exp_err[0], exp_err[0]});
    endtask

    task automatic drive_idx(input int i);
        bw.enc_a = gray[i][1];
        bw.enc_b = gray[i][0];
    endtask

    task automatic watch(input int cycles);
        nu_w = 0; nd_w = 0; nu_s = 0; nd_s = 0; pos_u = 0; pos_d = 0; both = 0;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clk); #1;
            if (bw.up)   begin nu_w++; if (pos_u == 0) pos_u = k; end
            if (bw.down) begin nd_w++; if (pos_d == 0) pos_d = k; end
            if (bs.up)   nu_s++;
            if (bs.down) nd_s++;
            if ((bw.up && bw.down) || (bs.up && bs.down)) both++;
        end
    endtask

    task automatic check_strobes(input string tag, input int s);
        check({tag, "_up_w"}, nu_w, (s == 1) ? 1 : 0);
        check({tag, "_dn_w"}, nd_w, (s == -1) ? 1 : 0);
        check({tag, "_up_s"}, nu_s, (s == 1) ? 1 : 0);
        check({tag, "_dn_s"}, nd_s, (s == -1) ? 1 : 0);
        check({tag, "_both"}, both, 0);
        if (s == 1)  check({tag, "_lat_up"}, pos_u, LAT);
        if (s == -1) check({tag, "_lat_dn"}, pos_d, LAT);
    endtask

    task automatic do_step(input string tag, input int d);
        int s;
        s = 0;
        idx = (idx + d + 4) % 4;
        drive_idx(idx);
        acc += d;
        if (acc == CPD)  begin acc = 0; s = 1;  end
        if (acc == -CPD) begin acc = 0; s = -1; end
        if (s != 0) begin
            exp_dir = (s == 1) ? 1 : 0;
            if (bw.count_en) begin
                cnt_w = (cnt_w + s + 1000) % 1000;
                cnt_s = cnt_s + s;
                if (cnt_s > 999) cnt_s = 999;
                if (cnt_s < 0)   cnt_s = 0;
            end
        end
        watch($urandom_range(9, 12));
        check_strobes(tag, s);
        check_state(tag);
    endtask

    task automatic detent(input string tag, input int d);
        for (int q = 0; q < CPD; q++) do_step(tag, d);
    endtask

    task automatic glitch(input string tag);
        int glen;
        glen = $urandom_range(1, DEB - 1);
        bw.enc_a = ~bw.enc_a;
        repeat (glen) @(posedge clk);
        #1 bw.enc_a = ~bw.enc_a;
        watch(12);
        check_strobes(tag, 0);
        check_state(tag);
    endtask

    task automatic illegal_jump(input string tag);
        idx = (idx + 2) % 4;
        drive_idx(idx);
        exp_err = 1;
        watch(12);
        check_strobes(tag, 0);
        check_state(tag);
    endtask

    task automatic pulse_clear(input string tag);
        bw.clear = 1'b1;
        @(posedge clk); #1;
        bw.clear = 1'b0;
        cnt_w = 0; cnt_s = 0; acc = 0; exp_err = 0;
        watch(4);
        check_strobes(tag, 0);
        check_state(tag);
    endtask

    task automatic apply_reset(input string tag);
        reset_n = 1'b0;
        #2;
        cnt_w = 0; cnt_s = 0; acc = 0; exp_err = 0; exp_dir = 0;
        check({tag, "_rst_strobe"}, {28'd0, bw.up, bw.down, bs.up, bs.down}, 32'd0);
        check_state({tag, "_rst"});
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        watch(DEB + 10);
        check_strobes({tag, "_init"}, 0);
        check_state({tag, "_init"});
    endtask

    initial begin
        bw.clear = 1'b0;
        bw.count_en = 1'b1;
        idx = 2;
        drive_idx(idx);
        acc = 0; cnt_w = 0; cnt_s = 0; exp_dir = 0; exp_err = 0;
        #1;
        apply_reset("t1");

        detent("t2_fwd", 1);
        glitch("t3_glitch");

        apply_reset("t4");
        detent("t4_rev", -1);
        detent("t4_wrap_up", 1);

        apply_reset("t5");
        for (int n = 0; n < 99; n++) detent("t5_fwd", 1);
        check_state("t5_099");
        detent("t5_100", 1);
        detent("t5_back", -1);
        bw.count_en = 1'b0;
        detent("t5_hold", 1);
        bw.count_en = 1'b1;

        apply_reset("t6");
        illegal_jump("t6_ill");
        do_step("t6_p", 1);
        do_step("t6_p", 1);
        do_step("t6_m", -1);
        do_step("t6_m", -1);
        pulse_clear("t6_clr");

        do_step("t7_mid", 1);
        do_step("t7_mid", 1);
        apply_reset("t7");
        do_step("t7_after", 1);
        do_step("t7_after", 1);

        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 45)      do_step("rnd_fwd", 1);
            else if (r < 78) do_step("rnd_rev", -1);
            else if (r < 85) glitch("rnd_glitch");
            else if (r < 88) illegal_jump("rnd_ill");
            else if (r < 92) pulse_clear("rnd_clr");
            else begin
                bw.count_en = ~bw.count_en;
                @(posedge clk); #1;
                check_state("rnd_en");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
